// File: rtl/ariane_regfile_lvt.sv
// Multi-port register file: one distributed-RAM bank per write port, with a live-value
// table selecting the bank that holds the newest copy of each word, plus a clear sequencer.
module ariane_regfile_lvt #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned NR_READ_PORTS  = 2,
   parameter int unsigned NR_WRITE_PORTS = 2,
   parameter int unsigned NUM_WORDS      = 32,
   parameter bit          ZERO_REG_ZERO  = 1'b0,
   parameter bit          WRITE_BYPASS   = 1'b0,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   localparam int unsigned AW = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      clear_i,
   output logic                      ready_o,
   input  logic [AW-1:0]             raddr_i [NR_READ_PORTS],
   output logic [DATA_WIDTH-1:0]     rdata_o [NR_READ_PORTS],
   input  logic [AW-1:0]             waddr_i [NR_WRITE_PORTS],
   input  logic [DATA_WIDTH-1:0]     wdata_i [NR_WRITE_PORTS],
   input  logic [NR_WRITE_PORTS-1:0] we_i
);

   localparam int unsigned LW = (NR_WRITE_PORTS > 1) ? $clog2(NR_WRITE_PORTS) : 1;
   localparam logic [AW-1:0] LAST_WORD = AW'(NUM_WORDS - 1);

   typedef enum logic {S_CLEAR, S_READY} state_t;

   state_t                    state;
   logic                      ready_q;
   logic [AW-1:0]             cnt;
   logic [LW-1:0]             lvt [NUM_WORDS];
   logic [DATA_WIDTH-1:0]     mem [NR_WRITE_PORTS][NUM_WORDS];
   logic [NR_WRITE_PORTS-1:0] wvalid;

   // Out-of-range words and (optionally) word 0 neither store nor return data.
   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < NUM_WORDS) && !(ZERO_REG_ZERO && (a == '0));
   endfunction

   assign ready_o = ready_q && !rst_i;

   always_comb begin
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
         wvalid[j] = ready_o && we_i[j] && addr_ok(waddr_i[j]);
      end
   end

   // NOTE: state uses non-blocking assignments only; for the LVT, the last NBA in loop
   // order wins, which gives the highest write port priority on an address collision.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
         ready_q <= !CLEAR_ON_RESET;
         cnt     <= '0;
         for (int w = 0; w < NUM_WORDS; w++) begin
            lvt[w] <= '0;
         end
      end else begin
         case (state)
            S_CLEAR: begin
               lvt[cnt] <= '0;
               if (clear_i) begin
                  cnt <= '0;
               end else if (cnt == LAST_WORD) begin
                  cnt     <= '0;
                  state   <= S_READY;
                  ready_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_READY: begin
               for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                  if (wvalid[j]) lvt[waddr_i[j]] <= LW'(j);
               end
               if (clear_i) begin
                  state   <= S_CLEAR;
                  ready_q <= 1'b0;
                  cnt     <= '0;
               end
            end
         endcase
      end
   end

   // NOTE: the banks are deliberately left without reset so they map onto distributed RAM;
   // the clear sequence is the only thing that defines their contents.
   always_ff @(posedge clk_i) begin
      if (!rst_i && state == S_CLEAR) begin
         for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            mem[j][cnt] <= '0;
         end
      end else begin
         for (int j = 0; j < NR_WRITE_PORTS; j++) begin
            if (wvalid[j]) mem[j][waddr_i[j]] <= wdata_i[j];
         end
      end
   end

   always_comb begin
      for (int k = 0; k < NR_READ_PORTS; k++) begin
         rdata_o[k] = '0;
         if (ready_o && addr_ok(raddr_i[k])) begin
            rdata_o[k] = mem[lvt[raddr_i[k]]][raddr_i[k]];
            if (WRITE_BYPASS) begin
               for (int j = 0; j < NR_WRITE_PORTS; j++) begin
                  if (wvalid[j] && waddr_i[j] == raddr_i[k]) rdata_o[k] = wdata_i[j];
               end
            end
         end
      end
   end

endmodule
